// File: rtl/inst_mem_sync.sv
// inst_mem_sync: clocked instruction memory with a boot-loader write port and
// a registered, one-cycle-latency fetch port (valid/ready handshake + stall).
// A LOAD/RUN mode machine keeps loader writes and fetches mutually exclusive.
// Optional build macro: INST_MEM_PARITY_EN adds a stored even-parity bit per
// word, parity checking on fetch, and a sticky parity_err output.
module inst_mem_sync #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 8192,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          write_address,
    input  logic [DATA_W-1:0]          instruc_data,
    input  logic                       load_done,
    output logic                       running,
    output logic [$clog2(DEPTH+1)-1:0] load_cnt,
    input  logic                       fetch_req,
    input  logic [ADDR_W-1:0]          fetch_address,
    output logic                       fetch_ready,
    input  logic                       fetch_stall,
    output logic [DATA_W-1:0]          instruction,
    output logic                       inst_valid,
`ifdef INST_MEM_PARITY_EN
    output logic                       parity_err,
`endif
    output logic                       fetch_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {ST_LOAD, ST_RUN} state_t;

    state_t state;

    logic [DATA_W-1:0] mem [DEPTH];
`ifdef INST_MEM_PARITY_EN
    logic              mem_par [DEPTH];
`endif

    // Aligned and inside the DEPTH-word array.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a[1:0] == 2'b00) && (a[ADDR_W-1:2] < (ADDR_W-2)'(DEPTH));
    endfunction

    // Word index used once addr_ok has qualified the address.
    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return a[IDX_W+1:2];
    endfunction

    // Load counter sticks at DEPTH rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_W'(DEPTH)) ? c : c + CNT_W'(1);
    endfunction

    logic              wr_fire_p0;
    logic              accept_p0;
    logic              rd_ok_p0;
    logic [DATA_W-1:0] rd_word_p0;
`ifdef INST_MEM_PARITY_EN
    logic              rd_par_bad_p0;
`endif

    assign running     = (state == ST_RUN);
    assign fetch_ready = running && !fetch_stall;
    assign wr_fire_p0  = (state == ST_LOAD) && wr_en && addr_ok(write_address);
    assign accept_p0   = fetch_req && fetch_ready;
    assign rd_ok_p0    = addr_ok(fetch_address);
    assign rd_word_p0  = mem[word_idx(fetch_address)];
`ifdef INST_MEM_PARITY_EN
    assign rd_par_bad_p0 = (^rd_word_p0) != mem_par[word_idx(fetch_address)];
`endif

    // ---- stage p0 -> storage: loader writes, never reset so contents survive ----
    // Store accepted loader words (and their parity bit when enabled).
    always_ff @(posedge clk) begin
        if (wr_fire_p0) begin
            mem[word_idx(write_address)] <= instruc_data;
`ifdef INST_MEM_PARITY_EN
            mem_par[word_idx(write_address)] <= ^instruc_data;
`endif
        end
    end

    // Mode machine and saturating count of accepted loader words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_LOAD;
            load_cnt <= '0;
        end else begin
            if (wr_fire_p0)
                load_cnt <= sat_inc(load_cnt);
            if (state == ST_LOAD && load_done)
                state <= ST_RUN;
        end
    end

    // ---- stage p0 -> p1: registered fetch outputs ----
    // Register the fetched word; hold everything while the IF stage stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instruction <= '0;
            inst_valid  <= 1'b0;
            fetch_err   <= 1'b0;
`ifdef INST_MEM_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else if (fetch_ready) begin
            if (accept_p0) begin
                inst_valid <= 1'b1;
                if (!rd_ok_p0) begin
                    instruction <= NOP_WORD;
                    fetch_err   <= 1'b1;
                end else begin
                    // A parity fault still returns the raw word for debug.
                    instruction <= rd_word_p0;
`ifdef INST_MEM_PARITY_EN
                    fetch_err   <= rd_par_bad_p0;
                    if (rd_par_bad_p0)
                        parity_err <= 1'b1;
`else
                    fetch_err   <= 1'b0;
`endif
                end
            end else begin
                inst_valid <= 1'b0;
                fetch_err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inst_mem_sync.sv
// tb_inst_mem_sync: directed bench for inst_mem_sync with a word-level memory
// model and an expected-result queue for the fetch port.
module tb_inst_mem_sync;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 8192;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] write_address = '0;
    logic [DATA_W-1:0] instruc_data = '0;
    logic              load_done = 1'b0;
    logic              running;
    logic [CNT_W-1:0]  load_cnt;
    logic              fetch_req = 1'b0;
    logic [ADDR_W-1:0] fetch_address = '0;
    logic              fetch_ready;
    logic              fetch_stall = 1'b0;
    logic [DATA_W-1:0] instruction;
    logic              inst_valid;
    logic              fetch_err;
`ifdef INST_MEM_PARITY_EN
    logic              parity_err;
`endif

    inst_mem_sync #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .NOP_WORD(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .write_address(write_address),
        .instruc_data(instruc_data), .load_done(load_done), .running(running),
        .load_cnt(load_cnt), .fetch_req(fetch_req), .fetch_address(fetch_address),
        .fetch_ready(fetch_ready), .fetch_stall(fetch_stall), .instruction(instruction),
        .inst_valid(inst_valid),
`ifdef INST_MEM_PARITY_EN
        .parity_err(parity_err),
`endif
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] instr;
        logic              err;
    } exp_t;

    exp_t              sb[$];
    logic [DATA_W-1:0] mem_m [int];
    int                cnt_m;
    bit                run_m;
    logic [DATA_W-1:0] last_instr;
    logic              last_valid;
    logic              last_err;
    int                n_cmp;
    int                n_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic bit addr_ok(input logic [ADDR_W-1:0] a);
        return (a[1:0] == 2'b00) && (int'(a >> 2) < DEPTH);
    endfunction

    // Reference result of a fetch from the word model.
    function automatic exp_t model_fetch(input logic [ADDR_W-1:0] a);
        exp_t e;
        if (!addr_ok(a)) begin
            e.instr = 32'h0000_0000;
            e.err   = 1'b1;
        end else begin
            e.instr = mem_m[int'(a >> 2)];
            e.err   = 1'b0;
        end
        return e;
    endfunction

    // One loader cycle, with an optional load_done in the same cycle.
    task automatic load(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input bit we, input bit done);
        wr_en = we; write_address = a; instruc_data = d; load_done = done;
        @(posedge clk); #1;
        if (we && !run_m && addr_ok(a)) begin
            mem_m[int'(a >> 2)] = d;
            if (cnt_m < DEPTH) cnt_m++;
        end
        if (done) run_m = 1'b1;
        wr_en = 1'b0; load_done = 1'b0;
    endtask

    // One fetch-port cycle; queues the expectation when the request is accepted.
    task automatic cyc(input bit req, input logic [ADDR_W-1:0] a, input bit stall, input string tag);
        exp_t e;
        bit   acc;
        fetch_req = req; fetch_address = a; fetch_stall = stall;
        #1;
        check({tag, "_ready"}, {31'd0, fetch_ready}, {31'd0, run_m && !stall});
        acc = req && run_m && !stall;
        if (acc) sb.push_back(model_fetch(a));
        @(posedge clk); #1;
        if (acc) begin
            e = sb.pop_front();
            check({tag, "_instr"}, instruction, e.instr);
            check({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
            check({tag, "_err"}, {31'd0, fetch_err}, {31'd0, e.err});
            last_instr = e.instr; last_valid = 1'b1; last_err = e.err;
        end else if (run_m && !stall) begin
            check({tag, "_idle_valid"}, {31'd0, inst_valid}, 32'd0);
            check({tag, "_idle_hold"}, instruction, last_instr);
            last_valid = 1'b0; last_err = 1'b0;
        end else begin
            check({tag, "_hold_instr"}, instruction, last_instr);
            check({tag, "_hold_valid"}, {31'd0, inst_valid}, {31'd0, last_valid});
            check({tag, "_hold_err"}, {31'd0, fetch_err}, {31'd0, last_err});
        end
        fetch_req = 1'b0; fetch_stall = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        run_m = 1'b0; cnt_m = 0;
        last_instr = '0; last_valid = 1'b0; last_err = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_bad = 0;
        do_reset();
        check("rst_instr", instruction, 32'h0);
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_err", {31'd0, fetch_err}, 32'd0);
        check("rst_running", {31'd0, running}, 32'd0);
        check("rst_cnt", 32'(load_cnt), 32'd0);

        // Boot load
        load(32'h0, 32'h2002_0005, 1'b1, 1'b0);
        load(32'h4, 32'h0041_8020, 1'b1, 1'b0);
        load(32'h8, 32'hAC03_0008, 1'b1, 1'b0);
        check("load_cnt3", 32'(load_cnt), 32'd3);
        load(32'h3, 32'hDEAD_BEEF, 1'b1, 1'b0);
        check("load_misalign_cnt", 32'(load_cnt), 32'(cnt_m));
        load(32'(DEPTH * 4), 32'hDEAD_BEEF, 1'b1, 1'b0);
        check("load_oor_cnt", 32'(load_cnt), 32'd3);
        cyc(1'b1, 32'h0, 1'b0, "load_fetch_ignored");
        check("load_fetch_valid", {31'd0, inst_valid}, 32'd0);
        check("load_not_running", {31'd0, running}, 32'd0);
        load(32'(DEPTH * 4 - 4), 32'h1234_5678, 1'b1, 1'b1);
        check("done_running", {31'd0, running}, 32'd1);
        check("done_cnt", 32'(load_cnt), 32'd4);

        // Sequential fetch
        cyc(1'b1, 32'h0, 1'b0, "seq0");
        cyc(1'b1, 32'h4, 1'b0, "seq4");
        cyc(1'b1, 32'h8, 1'b0, "seq8");
        cyc(1'b1, 32'(DEPTH * 4 - 4), 1'b0, "last_word");

        // Address errors
        cyc(1'b1, 32'h6, 1'b0, "err_misalign");
        cyc(1'b1, 32'(DEPTH * 4), 1'b0, "err_oor");
        cyc(1'b0, 32'h0, 1'b0, "idle");

        // Stall
        cyc(1'b1, 32'h4, 1'b0, "stall_pre");
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h8, 1'b1, "stall");
        check("stall_held_word", instruction, 32'h0041_8020);
        cyc(1'b1, 32'h8, 1'b0, "stall_post");
        check("stall_post_word", instruction, 32'hAC03_0008);

        // RUN write lockout and load_done ignored in RUN
        load(32'h0, 32'hFFFF_FFFF, 1'b1, 1'b1);
        check("run_cnt_frozen", 32'(load_cnt), 32'd4);
        cyc(1'b1, 32'h0, 1'b0, "lockout");
        check("lockout_word", instruction, 32'h2002_0005);

        // Asynchronous reset mid-fetch; contents retained
        cyc(1'b1, 32'h8, 1'b0, "prereset");
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", {31'd0, inst_valid}, 32'd0);
        check("async_running", {31'd0, running}, 32'd0);
        check("async_instr", instruction, 32'h0);
        check("async_cnt", 32'(load_cnt), 32'd0);
        do_reset();
        load(32'h0, 32'h0, 1'b0, 1'b1);
        cyc(1'b1, 32'h0, 1'b0, "retained0");
        check("retained_word", instruction, 32'h2002_0005);
        cyc(1'b1, 32'(DEPTH * 4 - 4), 1'b0, "retained_last");

        // Load counter saturation
        do_reset();
        for (int i = 0; i <= DEPTH; i++)
            load(32'((i % DEPTH) * 4), 32'(i), 1'b1, 1'b0);
        check("cnt_saturated", 32'(load_cnt), 32'(DEPTH));
        load(32'h0, 32'h0, 1'b0, 1'b1);
        cyc(1'b1, 32'h0, 1'b0, "sat_word0");
        cyc(1'b1, 32'(DEPTH * 4 - 4), 1'b0, "sat_wordlast");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_mem_sync.md
Name: inst_mem_sync

Overview:
- Clocked, parametrised successor of the combinational instruction memory.
- Holds DEPTH words of DATA_W bits and has a loader write port plus a registered fetch port with a valid/ready handshake and a stall input.
- A two-state mode machine separates boot loading from program execution.
- Sits between the testbench/boot loader and the IF stage of the MIPS pipeline.

Parameters:
- DATA_W, 32, instruction word width in bits.
- ADDR_W, 32, byte-address width of fetch_address and write_address.
- DEPTH, 8192, number of words; need not be a power of two.
- NOP_WORD, 32'h0000_0000, value driven on instruction for an erroneous fetch.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  loader write strobe.
- write_address  in  ADDR_W  loader byte address.
- instruc_data  in  DATA_W  loader write data.
- load_done  in  1  pulse; ends LOAD mode.
- running  out  1  high in RUN mode.
- load_cnt  out  $clog2(DEPTH+1)  count of words accepted in LOAD; saturates at DEPTH.
- fetch_req  in  1  fetch request.
- fetch_address  in  ADDR_W  fetch byte address (the PC).
- fetch_ready  out  1  the request is accepted this cycle.
- fetch_stall  in  1  IF stage stalled; hold the output.
- instruction  out  DATA_W  registered fetched word.
- inst_valid  out  1  instruction is valid.
- fetch_err  out  1  the fetch was misaligned or out of range; qualified by inst_valid.

Behaviour:
- Word index = address[ADDR_W-1:2]. An access is misaligned if address[1:0] != 0. It is out of range if the index is >= DEPTH.
- Reset, asynchronous:
  - instruction=0, inst_valid=0, fetch_err=0, running=0, load_cnt=0, state=LOAD.
  - Memory contents are not cleared and survive reset, including reset mid-operation.
- LOAD state:
  - fetch_ready=0, and fetch_req is ignored.
  - wr_en with an aligned, in-range address writes instruc_data into that word at the clock edge, and load_cnt increments (saturating).
  - wr_en with a misaligned or out-of-range address is dropped; no write, no count.
  - load_done=1 moves to RUN at the next edge. A wr_en in the same cycle is still performed.
- RUN state:
  - running=1, and wr_en is ignored; memory is read-only.
  - load_done is ignored; only reset returns to LOAD.
- Fetch handshake (RUN only):
  - fetch_ready = !fetch_stall.
  - When fetch_req && fetch_ready at edge N, the outputs at edge N+1 are instruction = mem[index], inst_valid=1, fetch_err=0. Latency is one cycle.
  - An erroneous address yields instruction=NOP_WORD and fetch_err=1, with inst_valid=1.
  - If fetch_stall=1, instruction, inst_valid and fetch_err hold their values unchanged.
  - If fetch_ready=1 and fetch_req=0, inst_valid=0 at the next edge and instruction holds its last value.
  - Back-to-back requests return one word per cycle.
- A same-address read and write cannot occur, because writes and fetches are mode-exclusive.
- The first fetch can be issued in the cycle after the LOAD->RUN transition.

Optional Feature:
- Macro: INST_MEM_PARITY_EN.
- When defined:
  - Each word stores an extra even-parity bit computed from instruc_data at write time.
  - The fetch path recomputes parity. On a mismatch it drives fetch_err=1 and instruction = the raw stored word, not NOP_WORD.
  - Adds a sticky output parity_err (1 bit), cleared only by reset.
- When not defined:
  - No parity storage and no parity_err port.
  - fetch_err reflects address errors only.

Test Plan:
- Reset then load: write 0x2002_0005 @0x0, 0x0041_8020 @0x4, 0xAC03_0008 @0x8, then pulse load_done -> load_cnt=3, running=1 the next cycle.
- Sequential fetch: requests at 0x0, 0x4, 0x8 in consecutive cycles -> instruction equals the three words at cycles +1/+2/+3, with inst_valid=1 and fetch_err=0.
- Errors:
  - Fetch at 0x6 -> instruction=0x0000_0000, fetch_err=1.
  - Fetch at DEPTH*4 -> same result.
  - A LOAD write at 0x3 leaves load_cnt unchanged.
- Stall: fetch 0x4, raise fetch_stall for 3 cycles while fetch_address=0x8 -> instruction stays 0x0041_8020 and fetch_ready=0; after the stall drops and the request is accepted at the next edge, 0xAC03_0008 appears one cycle later.
- RUN write lockout: in RUN, write 0xFFFF_FFFF @0x0 then fetch 0x0 -> returns 0x2002_0005.
- Reset mid-fetch: assert rst_n=0 asynchronously -> inst_valid=0 and running=0 immediately; after release, load_done then fetch 0x0 -> 0x2002_0005 (contents retained).
